// File: rtl/bp_fetch_stage.sv
// Fetch stage ahead of the branch predictor: owns the fetch PC, drives the I-cache
// read index, pairs 1-cycle cache data with its PC and registers a decode bundle.
module bp_fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IC_DEPTH_L = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall_in,
    input  logic                  fetch_redirect,
    input  logic [31:0]           fetch_redirect_PC,
    input  logic [31:0]           bpredictor_fetch_p_target,
    input  logic                  bpredictor_fetch_p_dir,
    output logic [IC_DEPTH_L-1:0] ic_rdaddress,
    input  logic [31:0]           ic_q,
    output logic [31:0]           fetch_bpredictor_PC,
    output logic [31:0]           fetch_bpredictor_inst,
    output logic                  fetch_valid,
    output logic                  fetch_decode_valid,
    output logic [31:0]           fetch_decode_PC,
    output logic [31:0]           fetch_decode_inst,
    output logic                  fetch_decode_pred_dir,
    output logic [31:0]           fetch_decode_pred_target,
    output logic [31:0]           fetch_count
);

    localparam logic [31:0] BOOT_PC = {RESET_PC[31:2], 2'b00};

    typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;

    state_t      state, state_next;
    logic [31:0] pc_f1, next_pc;
    logic        f1_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= BOOT;
            pc_f1    <= BOOT_PC;
            f1_valid <= 1'b0;
        end else begin
            state    <= state_next;
            pc_f1    <= next_pc;
            // Every state, including the single boot cycle, leaves a valid pc_f1/ic_q pair behind.
            f1_valid <= 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            BOOT:    state_next = RUN;
            RUN:     if (stall_in && !fetch_redirect) state_next = HOLD;
            HOLD:    if (!stall_in || fetch_redirect) state_next = RUN;
            default: state_next = BOOT;
        endcase
    end

    always_comb begin
        next_pc = pc_f1 + 32'd4;
        if (state == BOOT)
            next_pc = BOOT_PC;
        else if (fetch_redirect)
            next_pc = {fetch_redirect_PC[31:2], 2'b00};
        else if (stall_in)
            next_pc = pc_f1;
        else if (f1_valid && bpredictor_fetch_p_dir)
            next_pc = {bpredictor_fetch_p_target[31:2], 2'b00};
    end

    assign ic_rdaddress          = next_pc[IC_DEPTH_L+1:2];
    assign fetch_bpredictor_PC   = pc_f1;
    assign fetch_bpredictor_inst = ic_q;
    assign fetch_valid           = f1_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_decode_valid       <= 1'b0;
            fetch_decode_PC          <= '0;
            fetch_decode_inst        <= '0;
            fetch_decode_pred_dir    <= 1'b0;
            fetch_decode_pred_target <= '0;
            fetch_count              <= '0;
        end else if (!stall_in) begin
            fetch_decode_valid       <= f1_valid && !fetch_redirect;
            fetch_decode_PC          <= pc_f1;
            fetch_decode_inst        <= ic_q;
            fetch_decode_pred_dir    <= bpredictor_fetch_p_dir;
            fetch_decode_pred_target <= bpredictor_fetch_p_target;
            if (f1_valid && !fetch_redirect)
                fetch_count <= fetch_count + 32'd1;
        end else if (fetch_redirect) begin
            // Squash a held bundle even while decode is stalled.
            fetch_decode_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bp_fetch_stage.sv
// Directed bench for bp_fetch_stage; a behavioural 1-cycle cache returns
// 32'hA000_0000 | index so every instruction word identifies its fetch address.
module tb_bp_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_in;
    logic        fetch_redirect;
    logic [31:0] fetch_redirect_PC;
    logic [31:0] bpredictor_fetch_p_target;
    logic        bpredictor_fetch_p_dir;
    logic [7:0]  ic_rdaddress;
    logic [31:0] ic_q = '0;
    logic [31:0] fetch_bpredictor_PC;
    logic [31:0] fetch_bpredictor_inst;
    logic        fetch_valid;
    logic        fetch_decode_valid;
    logic [31:0] fetch_decode_PC;
    logic [31:0] fetch_decode_inst;
    logic        fetch_decode_pred_dir;
    logic [31:0] fetch_decode_pred_target;
    logic [31:0] fetch_count;

    int total = 0;
    int bad   = 0;

    bp_fetch_stage #(.RESET_PC(32'h0000_0000), .IC_DEPTH_L(8)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .stall_in                 (stall_in),
        .fetch_redirect           (fetch_redirect),
        .fetch_redirect_PC        (fetch_redirect_PC),
        .bpredictor_fetch_p_target(bpredictor_fetch_p_target),
        .bpredictor_fetch_p_dir   (bpredictor_fetch_p_dir),
        .ic_rdaddress             (ic_rdaddress),
        .ic_q                     (ic_q),
        .fetch_bpredictor_PC      (fetch_bpredictor_PC),
        .fetch_bpredictor_inst    (fetch_bpredictor_inst),
        .fetch_valid              (fetch_valid),
        .fetch_decode_valid       (fetch_decode_valid),
        .fetch_decode_PC          (fetch_decode_PC),
        .fetch_decode_inst        (fetch_decode_inst),
        .fetch_decode_pred_dir    (fetch_decode_pred_dir),
        .fetch_decode_pred_target (fetch_decode_pred_target),
        .fetch_count              (fetch_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ic_q <= 32'hA000_0000 | {24'h0, ic_rdaddress};

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall_in = 1'b0; fetch_redirect = 1'b0; fetch_redirect_PC = '0;
        bpredictor_fetch_p_dir = 1'b0; bpredictor_fetch_p_target = '0;
        #11;
        total++;
        if ({fetch_valid, fetch_bpredictor_PC, ic_rdaddress} !== {1'b0, 32'h0, 8'h00}) begin
            bad++; $display("FAIL reset_f1 got=%h exp=%h", {fetch_valid, fetch_bpredictor_PC, ic_rdaddress}, {1'b0, 32'h0, 8'h00});
        end
        total++;
        if ({fetch_decode_valid, fetch_decode_PC, fetch_decode_inst, fetch_decode_pred_dir, fetch_decode_pred_target, fetch_count} !== 130'h0) begin
            bad++; $display("FAIL reset_decode got valid=%b pc=%h cnt=%h exp all zero", fetch_decode_valid, fetch_decode_PC, fetch_count);
        end
        reset = 1'b0;   // released at t=11, boot edge at t=15
    endtask

    task automatic test_sequential();
        cyc();
        total++;
        if ({fetch_valid, fetch_bpredictor_PC, fetch_bpredictor_inst, ic_rdaddress, fetch_decode_valid} !== {1'b1, 32'h0, 32'hA000_0000, 8'h01, 1'b0}) begin
            bad++; $display("FAIL seq_boot got=%h exp=%h", {fetch_valid, fetch_bpredictor_PC, fetch_bpredictor_inst, ic_rdaddress, fetch_decode_valid}, {1'b1, 32'h0, 32'hA000_0000, 8'h01, 1'b0});
        end
        cyc();
        total++;
        if ({ic_rdaddress, fetch_decode_valid, fetch_decode_PC, fetch_decode_inst, fetch_count} !== {8'h02, 1'b1, 32'h0, 32'hA000_0000, 32'd1}) begin
            bad++; $display("FAIL seq_pc0 got=%h exp=%h", {ic_rdaddress, fetch_decode_valid, fetch_decode_PC, fetch_decode_inst, fetch_count}, {8'h02, 1'b1, 32'h0, 32'hA000_0000, 32'd1});
        end
        cyc();
        total++;
        if ({ic_rdaddress, fetch_decode_valid, fetch_decode_PC, fetch_decode_inst, fetch_count} !== {8'h03, 1'b1, 32'h4, 32'hA000_0001, 32'd2}) begin
            bad++; $display("FAIL seq_pc4 got=%h exp=%h", {ic_rdaddress, fetch_decode_valid, fetch_decode_PC, fetch_decode_inst, fetch_count}, {8'h03, 1'b1, 32'h4, 32'hA000_0001, 32'd2});
        end
    endtask

    task automatic test_stall();
        stall_in = 1'b1;
        #1;
        total++;
        if (ic_rdaddress !== 8'h02) begin
            bad++; $display("FAIL stall_rdaddr got=%h exp=02", ic_rdaddress);
        end
        for (int i = 0; i < 3; i++) begin
            cyc();
            total++;
            if ({ic_rdaddress, fetch_bpredictor_PC, fetch_decode_valid, fetch_decode_PC, fetch_count} !== {8'h02, 32'h8, 1'b1, 32'h4, 32'd2}) begin
                bad++; $display("FAIL stall_hold%0d got=%h exp=%h", i, {ic_rdaddress, fetch_bpredictor_PC, fetch_decode_valid, fetch_decode_PC, fetch_count}, {8'h02, 32'h8, 1'b1, 32'h4, 32'd2});
            end
        end
        stall_in = 1'b0;
        cyc();
        total++;
        if ({fetch_bpredictor_PC, fetch_decode_valid, fetch_decode_PC, fetch_decode_inst, fetch_count} !== {32'hC, 1'b1, 32'h8, 32'hA000_0002, 32'd3}) begin
            bad++; $display("FAIL stall_release got=%h exp=%h", {fetch_bpredictor_PC, fetch_decode_valid, fetch_decode_PC, fetch_decode_inst, fetch_count}, {32'hC, 1'b1, 32'h8, 32'hA000_0002, 32'd3});
        end
    endtask

    task automatic test_predict();
        cyc();
        bpredictor_fetch_p_dir = 1'b1; bpredictor_fetch_p_target = 32'h40;
        #1;
        total++;
        if ({fetch_bpredictor_PC, fetch_bpredictor_inst, ic_rdaddress} !== {32'h10, 32'hA000_0004, 8'h10}) begin
            bad++; $display("FAIL pred_lookup got=%h exp=%h", {fetch_bpredictor_PC, fetch_bpredictor_inst, ic_rdaddress}, {32'h10, 32'hA000_0004, 8'h10});
        end
        cyc();
        bpredictor_fetch_p_dir = 1'b0; bpredictor_fetch_p_target = '0;
        total++;
        if ({fetch_bpredictor_PC, fetch_decode_valid, fetch_decode_PC, fetch_decode_pred_dir, fetch_decode_pred_target, fetch_count} !== {32'h40, 1'b1, 32'h10, 1'b1, 32'h40, 32'd5}) begin
            bad++; $display("FAIL pred_taken got=%h exp=%h", {fetch_bpredictor_PC, fetch_decode_valid, fetch_decode_PC, fetch_decode_pred_dir, fetch_decode_pred_target, fetch_count}, {32'h40, 1'b1, 32'h10, 1'b1, 32'h40, 32'd5});
        end
    endtask

    task automatic test_redirect_stall();
        stall_in = 1'b1; fetch_redirect = 1'b1; fetch_redirect_PC = 32'h103;
        #1;
        total++;
        if (ic_rdaddress !== 8'h40) begin
            bad++; $display("FAIL redir_rdaddr got=%h exp=40", ic_rdaddress);
        end
        cyc();
        stall_in = 1'b0; fetch_redirect = 1'b0; fetch_redirect_PC = '0;
        total++;
        if ({fetch_bpredictor_PC, fetch_decode_valid, fetch_decode_PC, fetch_count} !== {32'h100, 1'b0, 32'h10, 32'd5}) begin
            bad++; $display("FAIL redir_squash got=%h exp=%h", {fetch_bpredictor_PC, fetch_decode_valid, fetch_decode_PC, fetch_count}, {32'h100, 1'b0, 32'h10, 32'd5});
        end
        cyc();
        total++;
        if ({fetch_decode_valid, fetch_decode_PC, fetch_decode_inst, fetch_count} !== {1'b1, 32'h100, 32'hA000_0040, 32'd6}) begin
            bad++; $display("FAIL redir_target got=%h exp=%h", {fetch_decode_valid, fetch_decode_PC, fetch_decode_inst, fetch_count}, {1'b1, 32'h100, 32'hA000_0040, 32'd6});
        end
    endtask

    task automatic test_wrap();
        fetch_redirect = 1'b1; fetch_redirect_PC = 32'hFFFF_FFFC;
        cyc();
        fetch_redirect = 1'b0; fetch_redirect_PC = '0;
        #1;
        total++;
        if ({fetch_bpredictor_PC, ic_rdaddress, fetch_decode_valid, fetch_count} !== {32'hFFFF_FFFC, 8'h00, 1'b0, 32'd6}) begin
            bad++; $display("FAIL wrap_rdaddr got=%h exp=%h", {fetch_bpredictor_PC, ic_rdaddress, fetch_decode_valid, fetch_count}, {32'hFFFF_FFFC, 8'h00, 1'b0, 32'd6});
        end
        cyc();
        total++;
        if ({fetch_bpredictor_PC, fetch_decode_valid, fetch_decode_PC, fetch_decode_inst, fetch_count} !== {32'h0, 1'b1, 32'hFFFF_FFFC, 32'hA000_00FF, 32'd7}) begin
            bad++; $display("FAIL wrap_next got=%h exp=%h", {fetch_bpredictor_PC, fetch_decode_valid, fetch_decode_PC, fetch_decode_inst, fetch_count}, {32'h0, 1'b1, 32'hFFFF_FFFC, 32'hA000_00FF, 32'd7});
        end
    endtask

    task automatic test_reset_mid();
        fetch_redirect = 1'b1; fetch_redirect_PC = 32'h80;
        cyc();
        fetch_redirect = 1'b0; fetch_redirect_PC = '0;
        total++;
        if ({fetch_valid, fetch_bpredictor_PC, fetch_count} !== {1'b1, 32'h80, 32'd7}) begin
            bad++; $display("FAIL midrst_pre got=%h exp=%h", {fetch_valid, fetch_bpredictor_PC, fetch_count}, {1'b1, 32'h80, 32'd7});
        end
        #1 reset = 1'b1;
        #1;
        total++;
        if ({fetch_valid, fetch_bpredictor_PC, ic_rdaddress, fetch_decode_valid, fetch_decode_PC, fetch_decode_inst, fetch_count} !== {1'b0, 32'h0, 8'h00, 1'b0, 32'h0, 32'h0, 32'h0}) begin
            bad++; $display("FAIL midrst_async got=%h exp=0", {fetch_valid, fetch_bpredictor_PC, ic_rdaddress, fetch_decode_valid, fetch_decode_PC, fetch_decode_inst, fetch_count});
        end
        @(negedge clk);
        reset = 1'b0;
        cyc();
        total++;
        if ({fetch_valid, fetch_bpredictor_PC, ic_rdaddress, fetch_decode_valid} !== {1'b1, 32'h0, 8'h01, 1'b0}) begin
            bad++; $display("FAIL midrst_boot got=%h exp=%h", {fetch_valid, fetch_bpredictor_PC, ic_rdaddress, fetch_decode_valid}, {1'b1, 32'h0, 8'h01, 1'b0});
        end
        cyc();
        total++;
        if ({fetch_decode_valid, fetch_decode_PC, fetch_decode_inst, fetch_count} !== {1'b1, 32'h0, 32'hA000_0000, 32'd1}) begin
            bad++; $display("FAIL midrst_first got=%h exp=%h", {fetch_decode_valid, fetch_decode_PC, fetch_decode_inst, fetch_count}, {1'b1, 32'h0, 32'hA000_0000, 32'd1});
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_predict();
        test_redirect_stall();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bp_fetch_stage.md
Name: bp_fetch_stage

Overview:
Fetch stage sitting directly upstream of the branch predictor. It owns the fetch PC register and drives the instruction-cache read address. It aligns the 1-cycle-latency cache data with its PC and presents the (inst, PC) pair to the predictor. It then picks the next PC from redirect, predictor target, or sequential, and registers a fetch bundle for decode with squash and stall handling.

Parameters:
RESET_PC, 32'h0000_0000, first PC fetched after reset (bits [1:0] treated as 0)
IC_DEPTH_L, 8, instruction-cache index width; index = PC[IC_DEPTH_L+1:2]

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
stall_in  in  1  decode cannot accept; hold fetch
fetch_redirect  in  1  execute-resolved redirect, highest priority
fetch_redirect_PC  in  32  redirect target
bpredictor_fetch_p_target  in  32  predictor target for fetch_bpredictor_PC
bpredictor_fetch_p_dir  in  1  predictor taken flag
ic_rdaddress  out  IC_DEPTH_L  cache read index (combinational from next_pc)
ic_q  in  32  cache data, valid 1 cycle after ic_rdaddress
fetch_bpredictor_PC  out  32  PC whose instruction is on ic_q (pc_f1)
fetch_bpredictor_inst  out  32  equals ic_q
fetch_valid  out  1  pc_f1/ic_q pair is valid
fetch_decode_valid  out  1  registered bundle valid
fetch_decode_PC  out  32  registered PC
fetch_decode_inst  out  32  registered instruction
fetch_decode_pred_dir  out  1  registered predictor direction
fetch_decode_pred_target  out  32  registered predictor target
fetch_count  out  32  number of bundles delivered to decode

Behaviour:
- States: BOOT, RUN, HOLD. Reset -> BOOT. pc_f1=RESET_PC, f1_valid=0. All fetch_decode_* = 0. fetch_count=0.
- BOOT: next_pc=RESET_PC. Next state RUN with f1_valid=1. Exactly one boot cycle.
- next_pc priority:
  - (1) fetch_redirect: {fetch_redirect_PC[31:2],2'b00}
  - (2) stall_in: pc_f1, so the cache re-reads the same index and ic_q stays stable
  - (3) f1_valid & p_dir: {p_target[31:2],2'b00}
  - (4) otherwise pc_f1+4, wrapping mod 2^32
- ic_rdaddress = next_pc[IC_DEPTH_L+1:2]. pc_f1 <= next_pc every cycle outside BOOT.
- f1_valid <= 1 in RUN/HOLD, and also on redirect. Redirect target data appears on ic_q the cycle after redirect.
- RUN -> HOLD when stall_in & ~fetch_redirect. HOLD -> RUN when ~stall_in or fetch_redirect.
- Decode register, loaded when ~stall_in:
  - valid <= f1_valid & ~fetch_redirect
  - PC/inst/dir/target <= pc_f1/ic_q/p_dir/p_target
- When stall_in: decode register holds its contents. Exception: fetch_redirect forces fetch_decode_valid=0 regardless of stall (squash).
- fetch_count increments (wrapping) on each cycle the decode register loads with valid=1.
- Simultaneous stall+redirect: redirect wins for pc_f1 and squashes decode valid. State -> RUN.
- Reset mid-operation clears everything asynchronously. First post-reset fetch is RESET_PC.

Test Plan:
- Reset, no stall, p_dir=0, RESET_PC=0 -> ic_rdaddress 0,1,2,3. Decode PCs 0x0,0x4,0x8 on consecutive cycles. fetch_count=3 after 3 valid loads.
- pc_f1=0x10, p_dir=1, p_target=0x40 -> next fetch_bpredictor_PC=0x40. Decode bundle for 0x10 carries dir=1, target=0x40.
- stall_in high 3 cycles at pc_f1=0x8 -> ic_rdaddress held at 2. Decode outputs frozen. fetch_count unchanged. Release -> 0xC follows.
- fetch_redirect with PC=0x103 while stall_in=1 -> pc_f1=0x100 next cycle. fetch_decode_valid=0. Next valid decode PC=0x100.
- pc_f1=0xFFFF_FFFC, p_dir=0 -> next PC 0x0000_0000 (wrap), ic_rdaddress=0.
- Assert reset mid-run at pc_f1=0x80 -> outputs zero immediately (async). After release: BOOT, then PC 0x0.
